// File: rtl/rr_mux_arb_pkg.sv
// rtl/rr_mux_arb_pkg.sv - shared helpers for round-robin arbiters and muxes
package rr_mux_arb_pkg;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_lock_e;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Pointer increment with wrap; a single channel keeps the pointer at 0.
  function automatic int unsigned ptr_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr and wraps
module rr_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter  int N     = 8,
  localparam int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  int             offset;
  int             idx;
  logic           found;

  // Duplicating the request vector turns the wrap-around into a plain slice.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: N];
    found   = 1'b0;
    offset  = 0;
    for (int j = 0; j < N; j++) begin
      if (!found && req_rot[j]) begin
        found  = 1'b1;
        offset = j;
      end
    end
    idx = int'(ptr) + offset;
    if (idx >= N) idx = idx - N;
    grant_idx = SEL_W'(idx);
    grant     = found ? (N'(1) << idx) : '0;
    any_grant = found;
  end

endmodule

// File: rtl/rr_mux_arb.sv
// rtl/rr_mux_arb.sv - N-channel round-robin mux with registered output; burst lock under RR_MUX_ARB_LOCK_EN
module rr_mux_arb
  import rr_mux_arb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 8,
  localparam int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N-1:0]     arb_req;
  logic [SEL_W-1:0] arb_ptr;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic             any_grant;
  logic             accept;
  logic             take;
  logic [SEL_W-1:0] next_ptr;

`ifdef RR_MUX_ARB_LOCK_EN
  arb_lock_e        lock_q, lock_d;
  logic [SEL_W-1:0] lock_idx_q, lock_idx_d;

  // While locked only the owning channel may request, and the search starts there.
  assign arb_req = (lock_q == ARB_LOCKED) ? (in_valid & (N'(1) << lock_idx_q)) : in_valid;
  assign arb_ptr = (lock_q == ARB_LOCKED) ? lock_idx_q : rr_ptr_q;
`else
  logic unused_last;
  assign unused_last = ^in_last;
  assign arb_req     = in_valid;
  assign arb_ptr     = rr_ptr_q;
`endif

  rr_arbiter #(.N(N)) u_arbiter (
    .req       (arb_req),
    .ptr       (arb_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign accept   = !out_valid_q || out_ready;
  assign take     = accept && any_grant;
  assign in_ready = accept ? grant : '0;
  assign next_ptr = SEL_W'(ptr_inc(32'(grant_idx), N));

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef RR_MUX_ARB_LOCK_EN
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
`endif
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_sel_d   = grant_idx;
`ifdef RR_MUX_ARB_LOCK_EN
      if (in_last[grant_idx]) begin
        lock_d   = ARB_FREE;
        rr_ptr_d = next_ptr;
      end else begin
        lock_d     = ARB_LOCKED;
        lock_idx_d = grant_idx;
      end
`else
      rr_ptr_d = next_ptr;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
`ifdef RR_MUX_ARB_LOCK_EN
      lock_q      <= ARB_FREE;
      lock_idx_q  <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef RR_MUX_ARB_LOCK_EN
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb/tb_rr_mux_arb.sv - scoreboard bench for rr_mux_arb (N=8 and N=1 instances)
module tb_rr_mux_arb;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_valid;
  logic [255:0] in_data;
  logic [7:0]   in_last;
  logic [7:0]   in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [2:0]   out_sel;
  logic         out_ready;

  logic         v1, r1, ov1, os1, l1, or1;
  logic [7:0]   d1, od1;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  logic [7:0] sbq1[$];

  always #5 clk = ~clk;

  rr_mux_arb #(.WIDTH(32), .N(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  rr_mux_arb #(.WIDTH(8), .N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_last(l1),
    .in_ready(r1), .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(or1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] chd(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  function automatic exp_t ex(input int s, input logic [31:0] d);
    exp_t e;
    e.sel  = 3'(s);
    e.data = d;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_beat", {29'd0, out_sel}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_sel", {29'd0, out_sel}, {29'd0, e.sel});
        check("sb_data", out_data, e.data);
      end
    end
    if (rst_n && ov1) begin
      if (sbq1.size() == 0) begin
        check("n1_unexpected", {24'd0, od1}, 32'hFFFF_FFFF);
      end else begin
        check("n1_data", {24'd0, od1}, {24'd0, sbq1.pop_front()});
        check("n1_sel", {31'd0, os1}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    bit done0, done4;
    rst_n = 1'b0; in_valid = '0; in_last = '0; out_ready = 1'b1;
    v1 = 1'b0; d1 = '0; l1 = 1'b0; or1 = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = chd(i);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_sel", {29'd0, out_sel}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: all channels valid, rotation 0..7,0 back to back
    for (int k = 0; k < 8; k++) sbq.push_back(ex(k, chd(k)));
    sbq.push_back(ex(0, chd(0)));
    in_valid = 8'hFF;
    #1;
    check("t1_first_ready", {24'd0, in_ready}, 32'h01);
    for (int k = 0; k < 9; k++) begin
      step();
      check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = '0;
    step();

    // 2: only ch5
    in_valid = 8'h20;
    #1;
    check("t2_ready", {24'd0, in_ready}, 32'h20);
    sbq.push_back(ex(5, 32'hA5A5_0005));
    step();
    in_valid = 8'hFF;
    #1;
    check("t2_ptr6", {24'd0, in_ready}, 32'h40);
    in_valid = '0;
    step();

    // 3: backpressure with ch2, ch3 valid
    in_valid = 8'h0C;
    sbq.push_back(ex(2, chd(2)));
    sbq.push_back(ex(3, chd(3)));
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t3_hold_ready", {24'd0, in_ready}, 32'h0);
      check("t3_hold_sel", {29'd0, out_sel}, 32'd2);
      check("t3_hold_data", out_data, chd(2));
      step();
    end
    out_ready = 1'b1;
    #1;
    check("t3_release_ready", {24'd0, in_ready}, 32'h08);
    step();
    in_valid = '0;
    step();

    // 4: single-channel instance
    v1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d1 = 8'h10 + 8'(k);
      sbq1.push_back(d1);
      #1;
      check("t4_ready", {31'd0, r1}, 32'd1);
      step();
      check("t4_valid", {31'd0, ov1}, 32'd1);
      check("t4_known", {31'd0, $isunknown({od1, os1})}, 32'd0);
    end
    v1 = 1'b0;
    step();

    // 5: ch1 burst of 3 against ch0 and ch4 (pointer first moved to 1)
    in_valid = 8'h01;
    sbq.push_back(ex(0, chd(0)));
    step();
    in_valid = '0;
    step();
`ifdef RR_MUX_ARB_LOCK_EN
    sbq.push_back(ex(1, 32'hB100_0000));
    sbq.push_back(ex(1, 32'hB100_0001));
    sbq.push_back(ex(1, 32'hB100_0002));
    sbq.push_back(ex(4, chd(4)));
    sbq.push_back(ex(0, chd(0)));
`else
    sbq.push_back(ex(1, 32'hB100_0000));
    sbq.push_back(ex(4, chd(4)));
    sbq.push_back(ex(0, chd(0)));
    sbq.push_back(ex(1, 32'hB100_0001));
    sbq.push_back(ex(1, 32'hB100_0002));
`endif
    n1 = 0; done0 = 0; done4 = 0;
    for (int c = 0; c < 12 && !(n1 == 3 && done0 && done4); c++) begin
      in_data[32 +: 32] = 32'hB100_0000 + 32'(n1);
      in_last[1]  = (n1 == 2);
      in_valid    = {3'b000, !done4, 2'b00, (n1 < 3), !done0};
      #1;
      if (in_ready[1]) n1++;
      if (in_ready[0]) done0 = 1;
      if (in_ready[4]) done4 = 1;
      step();
    end
    check("t5_complete", {31'd0, (n1 == 3 && done0 && done4)}, 32'd1);
    in_valid = '0; in_last = '0;
    in_data[32 +: 32] = chd(1);
    step();

    // 6: reset while a beat is held
    in_valid = 8'h01;
    out_ready = 1'b0;
    step();
    in_valid = '0;
    check("t6_held", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_data", out_data, 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 8'hFF;
    #1;
    check("t6_first_ready", {24'd0, in_ready}, 32'h01);
    sbq.push_back(ex(0, chd(0)));
    step();
    in_valid = '0;
    repeat (3) step();

    check("sb_drained", sbq.size(), 32'd0);
    check("n1_drained", sbq1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
